// File: rtl/i3c_tgt_pkg.sv
// Shared definitions for the I3C target-side engines: FSM state encoding,
// broadcast address, ENTHDRx CCC codes and HDR mode indices.
package i3c_tgt_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ACK,
        ST_CCC,
        ST_PAR
    } enthdr_state_e;

    typedef logic [2:0] hdr_mode_t;

    localparam logic [6:0] BCAST_ADDR_DEF = 7'h7E;

    localparam logic [7:0] CCC_ENTHDR0 = 8'h20;
    localparam logic [7:0] CCC_ENTHDR1 = 8'h21;
    localparam logic [7:0] CCC_ENTHDR2 = 8'h22;
    localparam logic [7:0] CCC_ENTHDR3 = 8'h23;
    localparam logic [7:0] CCC_ENTHDR4 = 8'h24;
    localparam logic [7:0] CCC_ENTHDR5 = 8'h25;
    localparam logic [7:0] CCC_ENTHDR6 = 8'h26;
    localparam logic [7:0] CCC_ENTHDR7 = 8'h27;

    localparam hdr_mode_t HDR_MODE_DDR = 3'd0;
    localparam hdr_mode_t HDR_MODE_TSP = 3'd1;
    localparam hdr_mode_t HDR_MODE_TSL = 3'd2;
    localparam hdr_mode_t HDR_MODE_BT  = 3'd3;

    // T bit makes the 9-bit {data, T} word odd parity.
    function automatic logic exp_t_bit(input logic [7:0] data);
        return ~^data;
    endfunction

endpackage

// File: rtl/i3c_tgt_enthdr_rx_if.sv
// SDA/SCL bus-side signals and the controller handshake of the ENTHDR receiver.
// slave = receiver side, master = edge logic / target controller side.
interface i3c_tgt_enthdr_rx_if;
    import i3c_tgt_pkg::*;

    logic      i_engine_en;
    logic      i_sda;
    logic      i_scl;
    logic      i_scl_pos_edge;
    logic      i_scl_neg_edge;
    logic      o_sda;
    logic      o_sda_oe;
    logic      o_engine_done;
    hdr_mode_t o_hdr_mode;
    logic      o_ccc_err;

    modport slave (
        input  i_engine_en, i_sda, i_scl, i_scl_pos_edge, i_scl_neg_edge,
        output o_sda, o_sda_oe, o_engine_done, o_hdr_mode, o_ccc_err
    );

    modport master (
        output i_engine_en, i_sda, i_scl, i_scl_pos_edge, i_scl_neg_edge,
        input  o_sda, o_sda_oe, o_engine_done, o_hdr_mode, o_ccc_err
    );

endinterface

// File: rtl/i3c_bus_cond_det.sv
// START/Sr and STOP detector: compares SDA against its registered previous
// value while SCL is high and emits one-cycle strobes.
module i3c_bus_cond_det (
    input  logic i_sys_clk,
    input  logic i_sys_rst,
    input  logic i_en,
    input  logic i_sda,
    input  logic i_scl,
    output logic o_start,
    output logic o_stop
);

    logic sda_prev_q;
    logic sda_prev_d;

    always_comb begin
        sda_prev_d = i_sda;
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge i_sys_clk or posedge i_sys_rst) begin
        if (i_sys_rst) begin
            sda_prev_q <= 1'b1;
        end else begin
            sda_prev_q <= sda_prev_d;
        end
    end

    assign o_start = i_en & i_scl &  sda_prev_q & ~i_sda;
    assign o_stop  = i_en & i_scl & ~sda_prev_q &  i_sda;

endmodule

// File: rtl/i3c_tgt_enthdr_rx.sv
// Target SDR header receiver for HDR entry: ACKs 7'h7E/W, receives CCC + T and
// reports a supported ENTHDRx as a mode index. Define
// I3C_TGT_ENTHDR_PARITY_CHK_EN to check the T bit; otherwise it is ignored.
module i3c_tgt_enthdr_rx
    import i3c_tgt_pkg::*;
#(
    parameter logic [6:0] BCAST_ADDR  = BCAST_ADDR_DEF,
    parameter logic [7:0] ENTHDR_BASE = CCC_ENTHDR0,
    parameter int         NUM_MODES   = 8,
    parameter logic [7:0] MODE_MASK   = 8'h01
) (
    input  logic                  i_sys_clk,
    input  logic                  i_sys_rst,
    i3c_tgt_enthdr_rx_if.slave    bus
);

    enthdr_state_e state_q, state_d;
    logic [2:0]    cnt_q, cnt_d;
    logic [7:0]    shift_q, shift_d;
    logic          byte_done_q, byte_done_d;
    logic          sda_q, sda_d;
    logic          sda_oe_q, sda_oe_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
    hdr_mode_t     mode_q, mode_d;

    logic          start_det;
    logic          stop_det;
    logic [8:0]    code_off;
    logic          code_ok;
    logic          par_err;

    i3c_bus_cond_det u_cond (
        .i_sys_clk (i_sys_clk),
        .i_sys_rst (i_sys_rst),
        .i_en      (bus.i_engine_en),
        .i_sda     (bus.i_sda),
        .i_scl     (bus.i_scl),
        .o_start   (start_det),
        .o_stop    (stop_det)
    );

    // Code classification runs on the received CCC byte held in shift_q.
    always_comb begin
        code_off = {1'b0, shift_q} - {1'b0, ENTHDR_BASE};
        code_ok  = !code_off[8] && (code_off < 9'(NUM_MODES))
                   && MODE_MASK[code_off[2:0]];
`ifdef I3C_TGT_ENTHDR_PARITY_CHK_EN
        par_err  = (bus.i_sda != exp_t_bit(shift_q));
`else
        par_err  = 1'b0;
`endif
    end

    // NOTE: every variable gets a default first so no latch can be inferred.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        shift_d     = shift_q;
        byte_done_d = byte_done_q;
        done_d      = 1'b0;
        err_d       = 1'b0;
        mode_d      = mode_q;

        if (!bus.i_engine_en) begin
            state_d     = ST_IDLE;
            cnt_d       = 3'd0;
            byte_done_d = 1'b0;
        end else if (stop_det) begin
            state_d     = ST_IDLE;
            cnt_d       = 3'd0;
            byte_done_d = 1'b0;
        end else if (start_det) begin
            state_d     = ST_ADDR;
            cnt_d       = 3'd0;
            byte_done_d = 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: ;
                ST_ADDR: begin
                    if (bus.i_scl_pos_edge && !byte_done_q) begin
                        shift_d     = {shift_q[6:0], bus.i_sda};
                        cnt_d       = cnt_q + 3'd1;
                        byte_done_d = (cnt_q == 3'd7);
                    end else if (bus.i_scl_neg_edge && byte_done_q) begin
                        byte_done_d = 1'b0;
                        cnt_d       = 3'd0;
                        state_d     = (shift_q == {BCAST_ADDR, 1'b0}) ? ST_ACK : ST_IDLE;
                    end
                end
                ST_ACK: begin
                    if (bus.i_scl_neg_edge) begin
                        state_d = ST_CCC;
                        cnt_d   = 3'd0;
                    end
                end
                ST_CCC: begin
                    if (bus.i_scl_pos_edge) begin
                        shift_d = {shift_q[6:0], bus.i_sda};
                        cnt_d   = cnt_q + 3'd1;
                        if (cnt_q == 3'd7) begin
                            state_d = ST_PAR;
                        end
                    end
                end
                ST_PAR: begin
                    if (bus.i_scl_pos_edge) begin
                        state_d = ST_IDLE;
                        if (par_err) begin
                            err_d = 1'b1;
                        end else if (code_ok) begin
                            done_d = 1'b1;
                            mode_d = code_off[2:0];
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end

        // SDA is pulled low exactly while the ACK state is occupied.
        sda_oe_d = (state_d == ST_ACK);
        sda_d    = ~sda_oe_d;
    end

    always_ff @(posedge i_sys_clk or posedge i_sys_rst) begin
        if (i_sys_rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 3'd0;
            shift_q     <= 8'h00;
            byte_done_q <= 1'b0;
            sda_q       <= 1'b1;
            sda_oe_q    <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            mode_q      <= HDR_MODE_DDR;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            shift_q     <= shift_d;
            byte_done_q <= byte_done_d;
            sda_q       <= sda_d;
            sda_oe_q    <= sda_oe_d;
            done_q      <= done_d;
            err_q       <= err_d;
            mode_q      <= mode_d;
        end
    end

    assign bus.o_sda         = sda_q;
    assign bus.o_sda_oe      = sda_oe_q;
    assign bus.o_engine_done = done_q;
    assign bus.o_hdr_mode    = mode_q;
    assign bus.o_ccc_err     = err_q;

endmodule
